// File: rtl/seg_scan_decoder.sv
// Seven-segment bus monitor: filters scan glitches, decodes each digit back to hex and
// rebuilds one frame per scan period. Define SEG_DEC_DP_EN to capture decimal points.
module seg_scan_decoder #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  cat,
  input  logic [7:0]  seg,
  output logic [31:0] frame_value,
  output logic [7:0]  frame_en,
  output logic [7:0]  dp_mask,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        cat_err
);

  localparam int SW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] STB_MAX = SW'(STABLE_CYCLES - 1);
  localparam logic [SW-1:0] STB_PRE = SW'(STABLE_CYCLES - 2);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SCAN = 1'b1} state_t;

  // Returns {illegal, digit_lit, nibble}; a blank digit is legal but unlit.
  function automatic logic [5:0] f_decode(input logic [6:0] p);
    case (p)
      7'h3F:   f_decode = {2'b01, 4'h0};
      7'h06:   f_decode = {2'b01, 4'h1};
      7'h5B:   f_decode = {2'b01, 4'h2};
      7'h4F:   f_decode = {2'b01, 4'h3};
      7'h66:   f_decode = {2'b01, 4'h4};
      7'h6D:   f_decode = {2'b01, 4'h5};
      7'h7D:   f_decode = {2'b01, 4'h6};
      7'h07:   f_decode = {2'b01, 4'h7};
      7'h7F:   f_decode = {2'b01, 4'h8};
      7'h6F:   f_decode = {2'b01, 4'h9};
      7'h77:   f_decode = {2'b01, 4'hA};
      7'h7C:   f_decode = {2'b01, 4'hB};
      7'h39:   f_decode = {2'b01, 4'hC};
      7'h5E:   f_decode = {2'b01, 4'hD};
      7'h79:   f_decode = {2'b01, 4'hE};
      7'h71:   f_decode = {2'b01, 4'hF};
      7'h00:   f_decode = {2'b00, 4'h0};
      default: f_decode = {2'b11, 4'h0};
    endcase
  endfunction

  logic [7:0] w_seg_in;
`ifdef SEG_DEC_DP_EN
  assign w_seg_in = seg;
`else
  logic w_unused_dp;
  assign w_unused_dp = seg[7];
  assign w_seg_in    = {1'b0, seg[6:0]};
`endif

  logic [7:0]    r_cat, r_seg, r_prev_cat, r_prev_seg;
  logic [SW-1:0] r_stb;
  logic [TW-1:0] r_tcnt;
  state_t        r_state;
  logic [31:0]   r_buf_val, r_frame_value;
  logic [7:0]    r_buf_en, r_buf_dp, r_buf_mask, r_frame_en, r_dp_mask;
  logic          r_buf_err, r_frame_err, r_frame_valid, r_cat_err;

  logic          w_same, w_hit, w_one, w_multi, w_accept, w_cat_bad, w_timeout, w_wrap;
  logic [7:0]    w_sel, w_sel_low, w_dbit, w_slot_en, w_slot_dp;
  logic [2:0]    w_digit;
  logic [5:0]    w_dec;
  logic [31:0]   w_slot_val;

  // Input register and stability counter; the cat reset value is "nothing selected".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cat      <= 8'hFF;
      r_seg      <= 8'h00;
      r_prev_cat <= 8'hFF;
      r_prev_seg <= 8'h00;
      r_stb      <= '0;
    end else begin
      r_cat      <= cat;
      r_seg      <= w_seg_in;
      r_prev_cat <= r_cat;
      r_prev_seg <= r_seg;
      if (!w_same)
        r_stb <= '0;
      else if (r_stb != STB_MAX)
        r_stb <= r_stb + SW'(1);
      else
        r_stb <= r_stb;
    end
  end

  assign w_same    = ({r_cat, r_seg} == {r_prev_cat, r_prev_seg});
  assign w_hit     = w_same && (r_stb == STB_PRE);
  assign w_sel     = ~r_cat;
  assign w_sel_low = w_sel & (w_sel - 8'd1);
  assign w_one     = (w_sel != 8'h00) && (w_sel_low == 8'h00);
  assign w_multi   = (w_sel_low != 8'h00);
  assign w_accept  = w_hit && w_one;
  assign w_cat_bad = w_hit && w_multi;
  assign w_timeout = (r_tcnt == TO_MAX);

  // Selected digit index from the one-hot cathode pattern.
  always_comb begin
    w_digit = 3'd0;
    for (int i = 0; i < 8; i++) begin
      w_digit = w_sel[i] ? 3'(i) : w_digit;
    end
  end

  assign w_dec      = f_decode(r_seg[6:0]);
  assign w_dbit     = 8'h01 << w_digit;
  assign w_slot_val = {28'h0, w_dec[3:0]} << {w_digit, 2'b00};
  assign w_slot_en  = w_dec[4] ? w_dbit : 8'h00;
  assign w_slot_dp  = r_seg[7] ? w_dbit : 8'h00;
  assign w_wrap     = w_accept && ((r_buf_mask & w_dbit) != 8'h00);

  // Frame assembly FSM with registered publish outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_tcnt        <= '0;
      r_buf_val     <= 32'h0;
      r_buf_en      <= 8'h00;
      r_buf_dp      <= 8'h00;
      r_buf_mask    <= 8'h00;
      r_buf_err     <= 1'b0;
      r_frame_value <= 32'h0;
      r_frame_en    <= 8'h00;
      r_dp_mask     <= 8'h00;
      r_frame_err   <= 1'b0;
      r_frame_valid <= 1'b0;
      r_cat_err     <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      r_cat_err     <= w_cat_bad;
      r_tcnt        <= r_tcnt + TW'(1);
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state    <= ST_SCAN;
            r_tcnt     <= '0;
            r_buf_val  <= w_slot_val;
            r_buf_en   <= w_slot_en;
            r_buf_dp   <= w_slot_dp;
            r_buf_mask <= w_dbit;
            r_buf_err  <= w_dec[5];
          end else if (w_timeout) begin
            r_tcnt        <= '0;
            r_frame_value <= 32'h0;
            r_frame_en    <= 8'h00;
            r_dp_mask     <= 8'h00;
            r_frame_err   <= 1'b0;
            r_frame_valid <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (w_wrap) begin
            r_tcnt        <= '0;
            r_frame_value <= r_buf_val;
            r_frame_en    <= r_buf_en;
            r_dp_mask     <= r_buf_dp;
            r_frame_err   <= r_buf_err;
            r_frame_valid <= 1'b1;
            r_buf_val     <= w_slot_val;
            r_buf_en      <= w_slot_en;
            r_buf_dp      <= w_slot_dp;
            r_buf_mask    <= w_dbit;
            r_buf_err     <= w_dec[5];
          end else if (w_accept) begin
            r_tcnt     <= '0;
            r_buf_val  <= r_buf_val | w_slot_val;
            r_buf_en   <= r_buf_en | w_slot_en;
            r_buf_dp   <= r_buf_dp | w_slot_dp;
            r_buf_mask <= r_buf_mask | w_dbit;
            r_buf_err  <= r_buf_err | w_dec[5];
          end else if (w_timeout) begin
            r_state       <= ST_IDLE;
            r_tcnt        <= '0;
            r_frame_value <= r_buf_val;
            r_frame_en    <= r_buf_en;
            r_dp_mask     <= r_buf_dp;
            r_frame_err   <= r_buf_err;
            r_frame_valid <= 1'b1;
            r_buf_val     <= 32'h0;
            r_buf_en      <= 8'h00;
            r_buf_dp      <= 8'h00;
            r_buf_mask    <= 8'h00;
            r_buf_err     <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign frame_value = r_frame_value;
  assign frame_en    = r_frame_en;
  assign dp_mask     = r_dp_mask;
  assign frame_valid = r_frame_valid;
  assign frame_err   = r_frame_err;
  assign cat_err     = r_cat_err;

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Monitor that sits on the multiplexed seven-segment bus (`cat`/`seg`) driven by the hex display scanner. It filters scan glitches, decodes each selected digit's segment pattern back to a hex nibble, and reassembles one 32-bit display frame plus an 8-bit digit-enable mask per scan period. It is used for on-chip self-check of the status display and as a scoreboard source in benches.

## Interface
Parameters:
- `STABLE_CYCLES`, 4: consecutive identical samples needed to accept a digit (min 2).
- `TIMEOUT_CYCLES`, 65536: cycles without an accepted digit before a forced frame publish.

Ports:
- `clk` input 1: system clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `cat` input 8: cathode select, active-low; `cat[i]`=0 selects digit i; digit 7 is leftmost, nibble [31:28].
- `seg` input 8: segments, active-high; `seg[0..6]` = a..g, `seg[7]` = dp.
- `frame_value` output 32: last published frame, hex nibble per digit.
- `frame_en` output 8: last published digit-enable mask.
- `dp_mask` output 8: last published decimal-point mask.
- `frame_valid` output 1: one-cycle pulse when `frame_*` update.
- `frame_err` output 1: published frame contained an illegal segment pattern; held with the frame.
- `cat_err` output 1: one-cycle pulse on an accepted multi-select `cat`.

## Operation
- Input stage: `cat`/`seg` registered once. Stability counter increments while registered {cat,seg} equals previous, resets to 0 on change, saturates.
- Accept event: the single cycle the counter reaches `STABLE_CYCLES-1`. Only one accept per stable period.
  - `cat`=8'hFF: no accept, no error.
  - More than one bit low: no accept, `cat_err` pulses.
  - Exactly one bit low, digit d: accept.
- Decode of `seg[6:0]`: 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 77→A, 7C→b, 39→C, 5E→d, 79→E, 71→F. 00 → nibble 0, en bit 0. Any other → nibble 0, en bit 1, frame error flag set.
- FSM states IDLE, SCAN; working buffers value/en/dp/captured-mask/err.
  - IDLE + accept: load digit d into cleared buffer, → SCAN.
  - SCAN + accept d not in captured mask: record d, stay.
  - SCAN + accept d already captured: publish buffer, clear, record d into new buffer in the same cycle, stay SCAN (frame wrap).
  - SCAN + timeout: publish partial buffer (missing digits nibble 0, en 0), → IDLE.
  - IDLE + timeout: publish blank frame (value 0, en 0, dp 0, err 0) once, counter restarts; stays IDLE.
- Timeout counter clears on every accept and on every publish.
- A digit re-captured before wrap is impossible by definition; the wrap rule owns it.

## Timing
- Reset: all outputs 0, FSM IDLE, buffers and counters 0.
- Input to accept: `STABLE_CYCLES` cycles after `cat`/`seg` settle (1 register + `STABLE_CYCLES-1` stable compares).
- Publish: `frame_*`, `dp_mask`, `frame_err` update and `frame_valid` pulses on the clock after the triggering accept or timeout; `frame_valid` never high two consecutive cycles.
- Timeout and wrap-accept in the same cycle: accept wins; timeout counter clears.
- Reset mid-scan: partial buffer discarded, no `frame_valid`.

## Configuration
- `SEG_DEC_DP_EN` defined: `seg[7]` captured per digit into `dp_mask`; `seg[7]` is part of the stability compare.
- Undefined: `dp_mask` tied 0; `seg[7]` ignored everywhere including stability compare.

## Test plan
- `STABLE_CYCLES`=4, `TIMEOUT_CYCLES`=64; scan digits 7..0, 10 cycles each, patterns 06,5B,4F,00×5, then digit 7 again → `frame_valid` one cycle, `frame_value`=32'h1230_0000, `frame_en`=8'hE0, `frame_err`=0.
- Digit 3 pattern 7F held only 2 cycles in an otherwise full scan of 00 → not captured; next frame `frame_en`=8'h00 bit 3 clear.
- `cat`=8'hFF for 64 cycles from IDLE → blank frame: value 0, en 0, `frame_valid` once; no further pulse until another 64 cycles.
- Digit 0 pattern 49 in a scan → published `frame_err`=1, nibble 0 = 0, `frame_en[0]`=1.
- `cat`=8'hFC stable 10 cycles → `cat_err` pulses once, no capture.
- `rst_n` low mid-scan after 4 digits → all outputs 0 immediately, no `frame_valid`; following full scan publishes correctly.
